// File: rtl/digit_entry_editor_pkg.sv
// digit_entry_editor_pkg: shared state encoding, digit width and cursor width helper
package digit_entry_editor_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic {ST_EDIT = 1'b0, ST_HOLD = 1'b1} state_t;
  function automatic int cursor_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/digit_entry_editor_digit_step.sv
// digit_step: modulo-RADIX increment/decrement of one digit, no carry or borrow out
module digit_step
  import digit_entry_editor_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic [DIGIT_W-1:0] d,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] d_next
);
  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(RADIX - 1);
  always_comb
    d_next = inc ? ((d == DMAX) ? '0 : d + 1'b1) :
             dec ? ((d == '0) ? DMAX : d - 1'b1) : d;
endmodule

// File: rtl/digit_entry_editor.sv
// digit_entry_editor: button-driven digit editor with a valid/ready commit port
module digit_entry_editor
  import digit_entry_editor_pkg::*;
#(
  parameter int NDIGITS         = 4,
  parameter int RADIX           = 10,
  parameter int CLEAR_ON_COMMIT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            up_pulse,
  input  logic                            down_pulse,
  input  logic                            left_pulse,
  input  logic                            right_pulse,
  input  logic                            enter_pulse,
  output logic [DIGIT_W*NDIGITS-1:0]      edit_value,
  output logic [cursor_w(NDIGITS)-1:0]    cursor,
  output logic                            editing,
  output logic [DIGIT_W*NDIGITS-1:0]      out_data,
  output logic                            out_valid,
  input  logic                            out_ready
);
  localparam int CW = cursor_w(NDIGITS);
  localparam logic [CW-1:0] CUR_MAX = CW'(NDIGITS - 1);
  if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
    $error("digit_entry_editor: RADIX must be 10 or 16");
  end
  if (NDIGITS < 2 || NDIGITS > 8) begin : g_bad_ndigits
    $error("digit_entry_editor: NDIGITS must be 2..8");
  end
  state_t                       state;
  logic                         in_edit, do_up, do_down, do_left, do_right;
  logic [DIGIT_W-1:0]           cur_digit, next_digit;
  logic [NDIGITS-1:0]           wr_en;
  logic [DIGIT_W*NDIGITS-1:0]   edit_next;
  assign in_edit  = (state == ST_EDIT);
  // enter > up > down > left > right; losers are simply dropped
  assign do_up    = in_edit & ~enter_pulse & up_pulse;
  assign do_down  = in_edit & ~enter_pulse & ~up_pulse & down_pulse;
  assign do_left  = in_edit & ~enter_pulse & ~up_pulse & ~down_pulse & left_pulse;
  assign do_right = in_edit & ~enter_pulse & ~up_pulse & ~down_pulse & ~left_pulse & right_pulse;
  assign cur_digit = edit_value[cursor*DIGIT_W +: DIGIT_W];
  digit_step #(.RADIX(RADIX)) u_step (
    .d      (cur_digit),
    .inc    (do_up),
    .dec    (do_down),
    .d_next (next_digit)
  );
  always_comb begin
    wr_en = (do_up | do_down) ? (NDIGITS'(1) << cursor) : '0;
    edit_next = edit_value;
    for (int i = 0; i < NDIGITS; i++)
      edit_next[i*DIGIT_W +: DIGIT_W] = wr_en[i] ? next_digit : edit_value[i*DIGIT_W +: DIGIT_W];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EDIT;
      edit_value <= '0;
      cursor     <= '0;
      editing    <= 1'b1;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else if (in_edit) begin
      edit_value <= edit_next;
      if (enter_pulse) begin
        out_data  <= edit_value;
        out_valid <= 1'b1;
        editing   <= 1'b0;
        state     <= ST_HOLD;
      end else if (do_left) begin
        cursor <= (cursor == CUR_MAX) ? '0 : cursor + 1'b1;
      end else if (do_right) begin
        cursor <= (cursor == '0) ? CUR_MAX : cursor - 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      editing   <= 1'b1;
      state     <= ST_EDIT;
      if (CLEAR_ON_COMMIT != 0) begin
        edit_value <= '0;
        cursor     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_digit_entry_editor.sv
// tb_digit_entry_editor: table-driven check of a BCD instance plus hand sequences on a hex instance
module tb_digit_entry_editor;
  localparam logic [4:0] EN = 5'b10000, UP = 5'b01000, DN = 5'b00100, LF = 5'b00010, RT = 5'b00001;
  typedef struct packed {
    logic [4:0]  p;
    logic        r;
    logic [15:0] ev;
    logic [1:0]  cur;
    logic        vld;
    logic [15:0] od;
    logic        ed;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_a, rst_b, rdy_a, rdy_b;
  logic [4:0]  p_a, p_b;
  logic [15:0] ev_a, ev_b, od_a, od_b;
  logic [1:0]  cur_a, cur_b;
  logic        ed_a, ed_b, ov_a, ov_b;
  int checks = 0, errors = 0;
  vec_t vq[$];
  digit_entry_editor #(.NDIGITS(4), .RADIX(10), .CLEAR_ON_COMMIT(1)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .up_pulse(p_a[3]), .down_pulse(p_a[2]), .left_pulse(p_a[1]), .right_pulse(p_a[0]), .enter_pulse(p_a[4]),
    .edit_value(ev_a), .cursor(cur_a), .editing(ed_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a)
  );
  digit_entry_editor #(.NDIGITS(4), .RADIX(16), .CLEAR_ON_COMMIT(1)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .up_pulse(p_b[3]), .down_pulse(p_b[2]), .left_pulse(p_b[1]), .right_pulse(p_b[0]), .enter_pulse(p_b[4]),
    .edit_value(ev_b), .cursor(cur_b), .editing(ed_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b)
  );
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(input logic [4:0] p, input logic r, input logic [15:0] ev, input logic [1:0] cur,
                     input logic vld, input logic [15:0] od, input logic ed);
    vq.push_back('{p: p, r: r, ev: ev, cur: cur, vld: vld, od: od, ed: ed});
  endtask
  task automatic step_a(input logic [4:0] p, input logic r);
    p_a = p;
    rdy_a = r;
    @(posedge clk);
    #1;
    p_a = '0;
  endtask
  task automatic step_b(input logic [4:0] p, input logic r);
    p_b = p;
    rdy_b = r;
    @(posedge clk);
    #1;
    p_b = '0;
  endtask
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; p_a = '0; p_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_a = 5'($urandom); rdy_a = 1'($urandom);
      p_b = 5'($urandom); rdy_b = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_val", ev_a, 16'h0000);
    chk("rst_cur", 16'(cur_a), 16'h0000);
    chk("rst_editing", 16'(ed_a), 16'h0001);
    chk("rst_valid", 16'(ov_a), 16'h0000);
    chk("rst_data", od_a, 16'h0000);
    chk("rst_b_val", ev_b, 16'h0000);
    p_a = '0; p_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    // BCD wrap on digit 0 with no carry, then down-wrap
    for (int k = 1; k <= 10; k++) add(UP, 0, (k == 10) ? 16'h0000 : 16'(k), 0, 0, 16'h0, 1);
    add(DN, 0, 16'h0009, 0, 0, 16'h0, 1);
    add(UP, 0, 16'h0000, 0, 0, 16'h0, 1);
    add(LF, 0, 16'h0000, 1, 0, 16'h0, 1);
    add(LF, 0, 16'h0000, 2, 0, 16'h0, 1);
    add(LF, 0, 16'h0000, 3, 0, 16'h0, 1);
    add(LF, 0, 16'h0000, 0, 0, 16'h0, 1);
    add(RT, 0, 16'h0000, 3, 0, 16'h0, 1);
    add(UP, 0, 16'h1000, 3, 0, 16'h0, 1);
    add(DN, 0, 16'h0000, 3, 0, 16'h0, 1);
    add(RT, 0, 16'h0000, 2, 0, 16'h0, 1);
    add(RT, 0, 16'h0000, 1, 0, 16'h0, 1);
    add(UP, 0, 16'h0010, 1, 0, 16'h0, 1);
    add(UP, 0, 16'h0020, 1, 0, 16'h0, 1);
    add(UP, 0, 16'h0030, 1, 0, 16'h0, 1);
    add(UP, 0, 16'h0040, 1, 0, 16'h0, 1);
    add(RT, 0, 16'h0040, 0, 0, 16'h0, 1);
    add(UP, 0, 16'h0041, 0, 0, 16'h0, 1);
    add(UP, 0, 16'h0042, 0, 0, 16'h0, 1);
    add(EN | UP, 0, 16'h0042, 0, 1, 16'h0042, 0);
    for (int k = 0; k < 20; k++) add((k % 2) ? LF : UP, 0, 16'h0042, 0, 1, 16'h0042, 0);
    add(5'b0, 1, 16'h0000, 0, 0, 16'h0042, 1);
    add(UP | DN, 0, 16'h0001, 0, 0, 16'h0042, 1);
    add(DN | LF, 0, 16'h0000, 0, 0, 16'h0042, 1);
    add(LF | RT, 0, 16'h0000, 1, 0, 16'h0042, 1);
    add(RT, 0, 16'h0000, 0, 0, 16'h0042, 1);
    add(RT, 0, 16'h0000, 3, 0, 16'h0042, 1);
    add(DN, 0, 16'h9000, 3, 0, 16'h0042, 1);
    add(EN, 1, 16'h9000, 3, 1, 16'h9000, 0);
    add(5'b0, 1, 16'h0000, 0, 0, 16'h9000, 1);
    foreach (vq[i]) begin
      step_a(vq[i].p, vq[i].r);
      chk($sformatf("v%0d_val", i), ev_a, vq[i].ev);
      chk($sformatf("v%0d_cur", i), 16'(cur_a), 16'(vq[i].cur));
      chk($sformatf("v%0d_valid", i), 16'(ov_a), 16'(vq[i].vld));
      chk($sformatf("v%0d_data", i), od_a, vq[i].od);
      chk($sformatf("v%0d_editing", i), 16'(ed_a), 16'(vq[i].ed));
    end
    // hex digit runs through F before wrapping
    for (int k = 0; k < 15; k++) step_b(UP, 0);
    chk("hex_f", ev_b, 16'h000F);
    step_b(UP, 0);
    chk("hex_wrap", ev_b, 16'h0000);
    step_b(DN, 0);
    chk("hex_down_wrap", ev_b, 16'h000F);
    step_b(EN, 0);
    chk("hex_hold_valid", 16'(ov_b), 16'h0001);
    chk("hex_hold_data", od_b, 16'h000F);
    rst_b = 1'b0;
    step_b(5'b0, 0);
    chk("hold_rst_valid", 16'(ov_b), 16'h0000);
    chk("hold_rst_editing", 16'(ed_b), 16'h0001);
    chk("hold_rst_val", ev_b, 16'h0000);
    chk("hold_rst_cur", 16'(cur_b), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
